// File: rtl/pbs_pkg.sv
// Shared definitions for the turn-based battle controller: FSM state encoding,
// move table lookups and roll LFSR taps.
package pbs_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_P_WAIT   = 4'd2,
        ST_P_ROLL   = 4'd3,
        ST_P_APPLY  = 4'd4,
        ST_P_CHECK  = 4'd5,
        ST_AI_SEL   = 4'd6,
        ST_AI_ROLL  = 4'd7,
        ST_AI_APPLY = 4'd8,
        ST_AI_CHECK = 4'd9,
        ST_WIN      = 4'd10,
        ST_LOSE     = 4'd11
    } state_t;

    localparam logic [3:0] LFSR_DEFAULT_SEED = 4'b1011;
    localparam int         LFSR_TAP_HI       = 3;
    localparam int         LFSR_TAP_LO       = 2;

    function automatic logic [3:0] move_dmg_of(input logic [1:0] move);
        case (move)
            2'd0:    return 4'd2;
            2'd1:    return 4'd4;
            2'd2:    return 4'd6;
            default: return 4'd9;
        endcase
    endfunction

    // Move 0 carries accuracy 15, so every 4-bit roll hits with it.
    function automatic logic [3:0] move_accu_of(input logic [1:0] move);
        case (move)
            2'd0:    return 4'd15;
            2'd1:    return 4'd10;
            2'd2:    return 4'd6;
            default: return 4'd3;
        endcase
    endfunction

endpackage

// File: rtl/pbs_lfsr4.sv
// 4-bit maximal-length Fibonacci LFSR used as the accuracy roll source;
// free-runs every cycle and cycles through all 15 nonzero values.
module pbs_lfsr4
    import pbs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] seed,
    output logic [3:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= seed;
        end else begin
            value <= {value[2:0], value[LFSR_TAP_HI] ^ value[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/pbs_turn_ctrl.sv
// Battle turn controller: sequences player and AI turns, rolls accuracy and
// issues single-cycle HP/damage commands to the datapath.
module pbs_turn_ctrl
    import pbs_pkg::*;
#(
    parameter logic [3:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [1:0] p_move,
    input  logic       ai_dead,
    input  logic       p_dead,
    input  logic       dbg_roll_en,
    input  logic [3:0] dbg_roll,
    output logic       load_ai_hp,
    output logic       apply_ai_damage,
    output logic       apply_p_damage,
    output logic       target,
    output logic       active_trainer,
    output logic [3:0] move_dmg,
    output logic [3:0] move_accu,
    output logic       hit,
    output logic       victory,
    output logic       loss,
    output logic [3:0] state
);

    state_t     cur_state, state_nxt;
    logic       go_q;
    logic       go_edge;
    logic [1:0] cur_move, cur_move_nxt;
    logic       hit_nxt;
    logic [3:0] lfsr_val;
    logic [3:0] roll;
    logic       roll_hit;

    pbs_lfsr4 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .value (lfsr_val)
    );

    assign go_edge   = go & ~go_q;
    assign move_dmg  = move_dmg_of(cur_move);
    assign move_accu = move_accu_of(cur_move);
    assign roll      = dbg_roll_en ? dbg_roll : lfsr_val;
    assign roll_hit  = (roll <= move_accu);
    assign state     = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_IDLE;
            go_q      <= 1'b0;
            cur_move  <= 2'd0;
            hit       <= 1'b0;
        end else begin
            cur_state <= state_nxt;
            go_q      <= go;
            cur_move  <= cur_move_nxt;
            hit       <= hit_nxt;
        end
    end

    // Go edges are only consumed in IDLE, P_WAIT, WIN and LOSE; elsewhere they fall through unused.
    always_comb begin
        state_nxt    = cur_state;
        cur_move_nxt = cur_move;
        hit_nxt      = hit;
        case (cur_state)
            ST_IDLE:     if (go_edge) state_nxt = ST_LOAD;
            ST_LOAD:     state_nxt = ST_P_WAIT;
            ST_P_WAIT: begin
                if (go_edge) begin
                    cur_move_nxt = p_move;
                    state_nxt    = ST_P_ROLL;
                end
            end
            ST_P_ROLL: begin
                hit_nxt   = roll_hit;
                state_nxt = roll_hit ? ST_P_APPLY : ST_AI_SEL;
            end
            ST_P_APPLY:  state_nxt = ST_P_CHECK;
            ST_P_CHECK:  state_nxt = ai_dead ? ST_WIN : ST_AI_SEL;
            ST_AI_SEL: begin
                cur_move_nxt = lfsr_val[1:0];
                state_nxt    = ST_AI_ROLL;
            end
            ST_AI_ROLL: begin
                hit_nxt   = roll_hit;
                state_nxt = roll_hit ? ST_AI_APPLY : ST_P_WAIT;
            end
            ST_AI_APPLY: state_nxt = ST_AI_CHECK;
            ST_AI_CHECK: state_nxt = p_dead ? ST_LOSE : ST_P_WAIT;
            ST_WIN,
            ST_LOSE:     if (go_edge) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ai_hp      = 1'b0;
        apply_ai_damage = 1'b0;
        apply_p_damage  = 1'b0;
        target          = 1'b0;
        active_trainer  = 1'b0;
        victory         = 1'b0;
        loss            = 1'b0;
        case (cur_state)
            ST_LOAD:     load_ai_hp = 1'b1;
            ST_P_APPLY: begin
                apply_ai_damage = 1'b1;
                target          = 1'b1;
            end
            ST_AI_SEL,
            ST_AI_ROLL,
            ST_AI_CHECK: active_trainer = 1'b1;
            ST_AI_APPLY: begin
                apply_p_damage = 1'b1;
                active_trainer = 1'b1;
            end
            ST_WIN:      victory = 1'b1;
            ST_LOSE:     loss    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Directed self-checking bench for pbs_turn_ctrl: reset, LFSR sequence,
// player/AI turns, win/lose, go-hold behaviour and mid-pulse reset.
module tb_pbs_turn_ctrl;

    logic       clk = 1'b0;
    logic       rst, go, ai_dead, p_dead, dbg_roll_en;
    logic [1:0] p_move;
    logic [3:0] dbg_roll;
    logic       load_ai_hp, apply_ai_damage, apply_p_damage, target, active_trainer;
    logic [3:0] move_dmg, move_accu, state;
    logic       hit, victory, loss;

    int num_checks = 0;
    int num_errors = 0;
    int lfsr_idx;
    logic [1:0] ai_move;

    // Hand-derived sequence starting from seed 4'b1011.
    logic [3:0] lfsr_tbl [15] = '{4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2,
                                  4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5};
    logic [3:0] dmg_tbl  [4]  = '{4'd2, 4'd4, 4'd6, 4'd9};
    logic [3:0] accu_tbl [4]  = '{4'd15, 4'd10, 4'd6, 4'd3};

    pbs_turn_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .go              (go),
        .p_move          (p_move),
        .ai_dead         (ai_dead),
        .p_dead          (p_dead),
        .dbg_roll_en     (dbg_roll_en),
        .dbg_roll        (dbg_roll),
        .load_ai_hp      (load_ai_hp),
        .apply_ai_damage (apply_ai_damage),
        .apply_p_damage  (apply_p_damage),
        .target          (target),
        .active_trainer  (active_trainer),
        .move_dmg        (move_dmg),
        .move_accu       (move_accu),
        .hit             (hit),
        .victory         (victory),
        .loss            (loss),
        .state           (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) lfsr_idx <= 0;
        else     lfsr_idx <= (lfsr_idx == 14) ? 0 : lfsr_idx + 1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic g, input logic [1:0] mv, input logic [3:0] roll);
        go       = g;
        p_move   = mv;
        dbg_roll = roll;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_state"}, 16'(state), 16'd0);
        checkOutput({tag, "_dmg"}, 16'(move_dmg), 16'd2);
        checkOutput({tag, "_accu"}, 16'(move_accu), 16'd15);
        checkOutput({tag, "_pulses"}, 16'({load_ai_hp, apply_ai_damage, apply_p_damage}), 16'd0);
        checkOutput({tag, "_flags"}, 16'({hit, target, active_trainer, victory, loss}), 16'd0);
        checkOutput({tag, "_lfsr"}, 16'(dut.u_lfsr.value), 16'hB);
    endtask

    initial begin
        int p_roll_visits;
        int ai_pulses;
        int multi_pulses;

        rst = 1'b1; go = 1'b0; p_move = 2'd0; ai_dead = 1'b0; p_dead = 1'b0;
        dbg_roll_en = 1'b0; dbg_roll = 4'd0;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkResetOutputs("reset");

        // Free-running LFSR over two full periods.
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("lfsr_seq", 16'(dut.u_lfsr.value), 16'(lfsr_tbl[(i + 1) % 15]));
        end
        checkOutput("idle_hold", 16'(state), 16'd0);
        dbg_roll_en = 1'b1;

        // Start battle, go stays high through LOAD and into P_WAIT.
        applyStimulus(1, 0, 15);
        checkOutput("load_state", 16'(state), 16'd1);
        checkOutput("load_pulse", 16'(load_ai_hp), 16'd1);
        applyStimulus(1, 0, 15);
        checkOutput("pwait_state", 16'(state), 16'd2);
        checkOutput("load_done", 16'(load_ai_hp), 16'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 15);
        checkOutput("pwait_no_retrig", 16'(state), 16'd2);
        applyStimulus(0, 0, 15);

        // Player move 0, roll 15 hits; p_dead must be ignored in P_CHECK.
        applyStimulus(1, 0, 15);
        checkOutput("p_roll_state", 16'(state), 16'd3);
        p_dead = 1'b1;
        applyStimulus(0, 0, 15);
        checkOutput("p_apply_state", 16'(state), 16'd4);
        checkOutput("p_apply_hit", 16'(hit), 16'd1);
        checkOutput("p_apply_pulses", 16'({apply_ai_damage, target, apply_p_damage, load_ai_hp}), 16'b1100);
        applyStimulus(0, 0, 15);
        checkOutput("p_check_state", 16'(state), 16'd5);
        checkOutput("p_check_pulse", 16'({apply_ai_damage, target}), 16'd0);
        applyStimulus(0, 0, 0);
        checkOutput("ai_sel_state", 16'(state), 16'd6);
        checkOutput("ai_sel_active", 16'(active_trainer), 16'd1);
        ai_move = lfsr_tbl[lfsr_idx][1:0];

        // AI turn forced to hit; ai_dead must be ignored in AI_CHECK.
        p_dead = 1'b0; ai_dead = 1'b1;
        applyStimulus(0, 0, 0);
        checkOutput("ai_roll_state", 16'(state), 16'd7);
        checkOutput("ai_move_dmg", 16'(move_dmg), 16'(dmg_tbl[ai_move]));
        checkOutput("ai_move_accu", 16'(move_accu), 16'(accu_tbl[ai_move]));
        applyStimulus(0, 0, 0);
        checkOutput("ai_apply_state", 16'(state), 16'd8);
        checkOutput("ai_apply_pulses", 16'({apply_p_damage, target, apply_ai_damage}), 16'b100);
        applyStimulus(0, 0, 0);
        checkOutput("ai_check_state", 16'(state), 16'd9);
        checkOutput("ai_check_pulse", 16'(apply_p_damage), 16'd0);
        applyStimulus(0, 0, 0);
        checkOutput("back_pwait", 16'(state), 16'd2);
        checkOutput("back_pwait_active", 16'(active_trainer), 16'd0);
        ai_dead = 1'b0;

        // Player move 3, roll 4 misses.
        applyStimulus(1, 3, 4);
        checkOutput("p3_state", 16'(state), 16'd3);
        checkOutput("p3_dmg", 16'(move_dmg), 16'd9);
        checkOutput("p3_accu", 16'(move_accu), 16'd3);
        applyStimulus(0, 3, 4);
        checkOutput("p3_miss_state", 16'(state), 16'd6);
        checkOutput("p3_miss_hit", 16'(hit), 16'd0);
        checkOutput("p3_miss_pulse", 16'(apply_ai_damage), 16'd0);
        checkOutput("p3_miss_active", 16'(active_trainer), 16'd1);
        ai_move = lfsr_tbl[lfsr_idx][1:0];
        applyStimulus(0, 0, 0);
        checkOutput("ai2_move_dmg", 16'(move_dmg), 16'(dmg_tbl[ai_move]));
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("ai2_back_pwait", 16'(state), 16'd2);

        // Win path.
        applyStimulus(1, 0, 15);
        applyStimulus(0, 0, 15);
        ai_dead = 1'b1;
        applyStimulus(0, 0, 15);
        checkOutput("win_pcheck", 16'(state), 16'd5);
        applyStimulus(0, 0, 15);
        checkOutput("win_state", 16'(state), 16'd10);
        checkOutput("win_victory", 16'(victory), 16'd1);
        ai_dead = 1'b0;
        applyStimulus(0, 0, 15);
        applyStimulus(0, 0, 15);
        checkOutput("win_hold", 16'({state, victory}), 16'({4'd10, 1'b1}));
        applyStimulus(1, 0, 15);
        checkOutput("win_exit", 16'({state, victory}), 16'd0);

        // Lose path: player misses, AI hits, p_dead set in AI_CHECK.
        applyStimulus(0, 0, 15);
        applyStimulus(1, 0, 15);
        applyStimulus(1, 0, 15);
        applyStimulus(0, 0, 15);
        checkOutput("lose_pwait", 16'(state), 16'd2);
        applyStimulus(1, 3, 15);
        applyStimulus(0, 3, 15);
        checkOutput("lose_p_miss", 16'(state), 16'd6);
        applyStimulus(0, 3, 0);
        applyStimulus(0, 3, 0);
        checkOutput("lose_ai_apply", 16'(state), 16'd8);
        p_dead = 1'b1;
        applyStimulus(0, 3, 0);
        applyStimulus(0, 3, 0);
        checkOutput("lose_state", 16'(state), 16'd11);
        checkOutput("lose_loss", 16'({loss, victory}), 16'b10);
        applyStimulus(0, 3, 0);
        checkOutput("lose_hold", 16'(loss), 16'd1);
        p_dead = 1'b0;
        rst = 1'b1;
        applyStimulus(0, 0, 0);
        checkResetOutputs("rst_lose");
        rst = 1'b0;

        // go held high 20 cycles from P_WAIT yields exactly one player turn.
        applyStimulus(1, 0, 15);
        applyStimulus(1, 0, 15);
        applyStimulus(0, 0, 15);
        p_roll_visits = 0; ai_pulses = 0; multi_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 15);
            if (state == 4'd3) p_roll_visits++;
            if (apply_ai_damage) ai_pulses++;
            if (32'(load_ai_hp) + 32'(apply_ai_damage) + 32'(apply_p_damage) > 1) multi_pulses++;
        end
        checkOutput("hold_p_rolls", 16'(p_roll_visits), 16'd1);
        checkOutput("hold_ai_pulses", 16'(ai_pulses), 16'd1);
        checkOutput("hold_multi_pulse", 16'(multi_pulses), 16'd0);
        checkOutput("hold_end_state", 16'(state), 16'd2);

        // Reset asserted while in P_APPLY.
        applyStimulus(0, 1, 5);
        applyStimulus(1, 1, 5);
        checkOutput("p1_dmg", 16'(move_dmg), 16'd4);
        applyStimulus(0, 1, 5);
        checkOutput("p1_apply", 16'({state, apply_ai_damage}), 16'({4'd4, 1'b1}));
        rst = 1'b1;
        applyStimulus(0, 1, 5);
        checkResetOutputs("rst_apply");
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule
